// File: rtl/alu_seq_ctrl.sv
// Sequence generator that drives an external combinational ALU:
// f(n) = f(n-2) op f(n-1), one term per cycle, with sticky signed-overflow tracking.
module alu_seq_ctrl #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [31:0]   seed0,
    input  logic [31:0]   seed1,
    input  logic [4:0]    op,
    input  logic [CW-1:0] count,
    output logic [31:0]   alu_a,
    output logic [31:0]   alu_b,
    output logic [4:0]    alu_op,
    input  logic [31:0]   alu_out,
    output logic [31:0]   term,
    output logic          term_valid,
    output logic          done,
    output logic          busy,
    output logic          err,
    output logic          ovf
);

    localparam logic [4:0] OP_ADD = 5'h01;
    localparam logic [4:0] OP_SUB = 5'h02;
    localparam logic [4:0] OP_MAX = 5'h06;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   prev_q, cur_q;
    logic [CW-1:0] rem_q;
    logic [4:0]    op_q;

    logic accept, reject, step, finish, ovf_hit;

    always_comb begin
        accept  = (state_q == IDLE) && start && (op <= OP_MAX);
        reject  = (state_q == IDLE) && start && (op > OP_MAX);
        step    = (state_q == RUN) && (rem_q != '0);
        finish  = (state_q == RUN) && ((rem_q == '0) || (rem_q == CW'(1)));
        busy    = (state_q == RUN);
        alu_a   = (state_q == RUN) ? prev_q : '0;
        alu_b   = (state_q == RUN) ? cur_q  : '0;
        alu_op  = (state_q == RUN) ? op_q   : '0;
        ovf_hit = 1'b0;
        if (op_q == OP_ADD)
            ovf_hit = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
        else if (op_q == OP_SUB)
            ovf_hit = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= '0;
            cur_q      <= '0;
            rem_q      <= '0;
            op_q       <= '0;
            term       <= '0;
            term_valid <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            term_valid <= 1'b0;
            done       <= 1'b0;
            err        <= reject;
            if (accept) begin
                prev_q <= seed0;
                cur_q  <= seed1;
                op_q   <= op;
                rem_q  <= count;
                ovf    <= 1'b0;
            end
            if (step) begin
                term       <= alu_out;
                term_valid <= 1'b1;
                prev_q     <= cur_q;
                cur_q      <= alu_out;
                rem_q      <= rem_q - CW'(1);
                if (ovf_hit) ovf <= 1'b1;
            end
            // count=0 finishes on the first RUN cycle without a term
            if (finish) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural ALU on the external port.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] seed0 = '0, seed1 = '0;
    logic [4:0]  op = '0;
    logic [7:0]  count = '0;
    logic [31:0] alu_a, alu_b, alu_out, term;
    logic [4:0]  alu_op;
    logic        term_valid, done, busy, err, ovf;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct packed {
        logic        is_term;
        logic        last;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.CW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1),
        .op(op), .count(count), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .term(term), .term_valid(term_valid), .done(done),
        .busy(busy), .err(err), .ovf(ovf)
    );

    function automatic logic [31:0] alu_fn(input logic [4:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
        case (o)
            5'h01:   return a + b;
            5'h02:   return a - b;
            5'h03:   return a & b;
            5'h04:   return a | b;
            5'h05:   return a ^ b;
            5'h06:   return ~(a | b);
            default: return '0;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_op, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (term_valid || done)) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {30'd0, term_valid, done}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("term_valid", {31'd0, term_valid}, {31'd0, mon_e.is_term});
                check("done", {31'd0, done}, {31'd0, mon_e.last});
                if (mon_e.is_term) check("term", term, mon_e.val);
            end
        end
    end

    // Builds the expected stream and ovf from the recurrence; returns the final term.
    task automatic predict(input logic [31:0] s0, input logic [31:0] s1, input logic [4:0] o,
                           input logic [7:0] n, output logic ovf_e, output logic [31:0] last_t);
        logic [31:0] a, b, r;
        a = s0; b = s1; ovf_e = 1'b0; last_t = '0;
        if (n == 0) sb.push_back('{is_term: 1'b0, last: 1'b1, val: 32'd0});
        for (int unsigned i = 0; i < n; i++) begin
            r = alu_fn(o, a, b);
            if (o == 5'h01 && a[31] == b[31] && r[31] != a[31]) ovf_e = 1'b1;
            if (o == 5'h02 && a[31] != b[31] && r[31] != a[31]) ovf_e = 1'b1;
            sb.push_back('{is_term: 1'b1, last: (i == n - 1), val: r});
            last_t = r;
            a = b; b = r;
        end
    endtask

    // no_wait drives start within the current (done) cycle; intrude pokes start during RUN.
    task automatic run_seq(input logic [31:0] s0, input logic [31:0] s1, input logic [4:0] o,
                           input logic [7:0] n, input bit no_wait, input bit intrude);
        logic        ovf_e;
        logic [31:0] last_t;
        int unsigned tail;
        predict(s0, s1, o, n, ovf_e, last_t);
        if (!no_wait) @(negedge clk);
        start = 1'b1; seed0 = s0; seed1 = s1; op = o; count = n;
        @(negedge clk);
        start = 1'b0;
        #1 check("busy_run", {31'd0, busy}, 32'd1);
        check("alu_a_run", alu_a, s0);
        tail = (n == 0) ? 1 : n;
        if (intrude) begin
            start = 1'b1; op = 5'h05; seed0 = 32'hDEAD; seed1 = 32'hBEEF; count = 8'd1;
            @(negedge clk);
            op = 5'h07;
            @(negedge clk);
            start = 1'b0;
            #1 check("err_in_run", {31'd0, err}, 32'd0);
            tail = tail - 2;
        end
        repeat (tail) @(negedge clk);
        #1 check("sb_drained", sb.size(), 32'd0);
        check("busy_end", {31'd0, busy}, 32'd0);
        check("ovf", {31'd0, ovf}, {31'd0, ovf_e});
        if (n != 0) check("term_last", term, last_t);
        sb.delete();
    endtask

    initial begin
        #2;
        check("rst_term", term, 32'd0);
        check("rst_flags", {27'd0, term_valid, done, busy, err, ovf}, 32'd0);
        check("rst_alu_op", {27'd0, alu_op}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_seq(32'd1, 32'd1, 5'h01, 8'd5, 1'b0, 1'b0);
        run_seq(32'd5, 32'd3, 5'h02, 8'd3, 1'b0, 1'b0);
        run_seq(32'h7FFF_FFFF, 32'd1, 5'h01, 8'd1, 1'b0, 1'b0);
        @(negedge clk);
        #1 check("ovf_held", {31'd0, ovf}, 32'd1);
        check("term_hold", term, 32'h8000_0000);

        // illegal op: err pulse only, ovf from previous run untouched
        start = 1'b1; op = 5'h07; seed0 = 32'd9; seed1 = 32'd9; count = 8'd4;
        @(negedge clk);
        start = 1'b0;
        #1 check("err_pulse", {31'd0, err}, 32'd1);
        check("err_busy", {31'd0, busy}, 32'd0);
        check("err_alu_op", {27'd0, alu_op}, 32'd0);
        check("err_ovf", {31'd0, ovf}, 32'd1);
        @(negedge clk);
        #1 check("err_one_cycle", {31'd0, err}, 32'd0);

        run_seq(32'd4, 32'd6, 5'h01, 8'd0, 1'b0, 1'b0);
        run_seq(32'h0000_F0F0, 32'h0000_FF00, 5'h03, 8'd3, 1'b1, 1'b0);
        run_seq(32'h1234_5678, 32'h0F0F_0F0F, 5'h05, 8'd4, 1'b1, 1'b0);
        run_seq(32'h0000_0001, 32'h0000_0002, 5'h06, 8'd3, 1'b1, 1'b0);
        run_seq(32'h8000_0000, 32'd1, 5'h02, 8'd2, 1'b0, 1'b0);
        run_seq(32'd1, 32'd2, 5'h04, 8'd5, 1'b0, 1'b1);

        // asynchronous reset after two of five terms
        begin
            logic        ovf_e;
            logic [31:0] last_t;
            predict(32'd1, 32'd1, 5'h01, 8'd5, ovf_e, last_t);
            @(negedge clk);
            start = 1'b1; seed0 = 32'd1; seed1 = 32'd1; op = 5'h01; count = 8'd5;
            @(negedge clk);
            start = 1'b0;
            repeat (2) @(negedge clk);
            #2 check("pre_rst_sb", sb.size(), 32'd3);
            check("pre_rst_busy", {31'd0, busy}, 32'd1);
            rst = 1'b1;
            #1 check("arst_term", term, 32'd0);
            check("arst_flags", {27'd0, term_valid, done, busy, err, ovf}, 32'd0);
            check("arst_alu", alu_a | alu_b | {27'd0, alu_op}, 32'd0);
            sb.delete();
            @(negedge clk);
            rst = 1'b0;
            repeat (4) @(negedge clk);
            #1 check("no_done_after_rst", {31'd0, done}, 32'd0);
        end
        run_seq(32'd1, 32'd1, 5'h01, 8'd5, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
